sobel_gradient_stream: RTL and testbench

//  Streaming 3x3 Sobel stage feeding result_2. Takes a raster-order 8-bit pixel stream and

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/sobel_line_buffer.sv | 34 +++
 rtl/sobel_gradient_stream.sv | 162 ++++++++++++++++
 tb/tb_sobel_gradient_stream.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// ============================================================================
// Module : sobel_pkg
// Brief  : Shared widths, pixel/gradient types and helpers for the Sobel stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sobel_pkg;
    localparam int PIX_W  = 8;
    localparam int GRAD_W = 11;

    typedef logic [PIX_W-1:0]         pixel_t;
    typedef logic signed [GRAD_W-1:0] grad_t;

    function automatic grad_t zext(input pixel_t p);
        return grad_t'({{(GRAD_W-PIX_W){1'b0}}, p});
    endfunction
endpackage

`default_nettype wire

// File: rtl/sobel_line_buffer.sv
// ============================================================================
// Module : sobel_line_buffer
// Brief  : One-line pixel store, single address, read-before-write per cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  pixel_t            wr_data,
    output pixel_t            rd_data
);

    pixel_t mem [DEPTH];

    // Combinational read returns the old word in the same cycle it is overwritten.
    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sobel_gradient_stream.sv
// ============================================================================
// Module : sobel_gradient_stream
// Brief  : Streaming 3x3 Sobel gx/gy with two internal line buffers.
//          Optional macro SOBEL_BORDER_ZERO_EN: emit zero results on border pixels.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sobel_gradient_stream
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     frame_start,
    input  logic                     pixel_valid,
    input  logic [PIX_W-1:0]         pixel_in,
    output logic signed [GRAD_W-1:0] gx_out,
    output logic signed [GRAD_W-1:0] gy_out,
    output logic                     grad_valid,
    output logic                     frame_done
);

    localparam int               COL_W    = $clog2(IMG_WIDTH);
    localparam int               ROW_W    = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] col_q, col_d, col_cur;
    logic [ROW_W-1:0] row_q, row_d, row_cur;
    pixel_t           win_q [3][3];
    pixel_t           win_d [3][3];
    logic             win_valid_q, win_valid_d;
    logic             win_last_q, win_last_d;
    grad_t            gx_q, gx_d, gy_q, gy_d;
    logic             grad_valid_q, grad_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             interior;
    pixel_t           lb0_rd, lb1_rd;
`ifdef SOBEL_BORDER_ZERO_EN
    logic             win_border_q, win_border_d;
`endif

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lb0 (
        .clk     (clk),
        .wr_en   (pixel_valid),
        .addr    (col_cur),
        .wr_data (pixel_in),
        .rd_data (lb0_rd)
    );

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lb1 (
        .clk     (clk),
        .wr_en   (pixel_valid),
        .addr    (col_cur),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // Stage 1: position counters and window shift; frame_start makes this pixel (0,0).
    always_comb begin
        col_cur     = frame_start ? '0 : col_q;
        row_cur     = frame_start ? '0 : row_q;
        interior    = (row_cur >= ROW_W'(2)) && (col_cur >= COL_W'(2));
        col_d       = col_cur;
        row_d       = row_cur;
        win_d       = win_q;
        win_valid_d = 1'b0;
        win_last_d  = win_last_q;
`ifdef SOBEL_BORDER_ZERO_EN
        win_border_d = win_border_q;
`endif
        if (pixel_valid) begin
            if (col_cur == COL_LAST) begin
                col_d = '0;
                row_d = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = pixel_in;
            win_last_d  = (row_cur == ROW_LAST) && (col_cur == COL_LAST);
`ifdef SOBEL_BORDER_ZERO_EN
            win_valid_d  = 1'b1;
            win_border_d = !interior;
`else
            win_valid_d  = interior;
`endif
        end
    end

    // Stage 2: gradient arithmetic; results hold through bubbles.
    always_comb begin
        gx_d         = gx_q;
        gy_d         = gy_q;
        grad_valid_d = 1'b0;
        frame_done_d = 1'b0;
        if (win_valid_q && !frame_start) begin
            grad_valid_d = 1'b1;
            frame_done_d = win_last_q;
            gx_d = (zext(win_q[0][2]) + (zext(win_q[1][2]) <<< 1) + zext(win_q[2][2]))
                 - (zext(win_q[0][0]) + (zext(win_q[1][0]) <<< 1) + zext(win_q[2][0]));
            gy_d = (zext(win_q[2][0]) + (zext(win_q[2][1]) <<< 1) + zext(win_q[2][2]))
                 - (zext(win_q[0][0]) + (zext(win_q[0][1]) <<< 1) + zext(win_q[0][2]));
`ifdef SOBEL_BORDER_ZERO_EN
            if (win_border_q) begin
                gx_d = '0;
                gy_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            gx_q         <= '0;
            gy_q         <= '0;
            grad_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef SOBEL_BORDER_ZERO_EN
            win_border_q <= 1'b0;
`endif
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            win_last_q   <= win_last_d;
            gx_q         <= gx_d;
            gy_q         <= gy_d;
            grad_valid_q <= grad_valid_d;
            frame_done_q <= frame_done_d;
`ifdef SOBEL_BORDER_ZERO_EN
            win_border_q <= win_border_d;
`endif
        end
    end

    assign gx_out     = gx_q;
    assign gy_out     = gy_q;
    assign grad_valid = grad_valid_q;
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_sobel_gradient_stream.sv
// ============================================================================
// Module : tb_sobel_gradient_stream
// Brief  : Self-checking bench for sobel_gradient_stream on a 4x4 image.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sobel_gradient_stream;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic               clk = 1'b0;
    logic               n_rst = 1'b0;
    logic               frame_start = 1'b0;
    logic               pixel_valid = 1'b0;
    logic [7:0]         pixel_in = '0;
    logic signed [10:0] gx_out, gy_out;
    logic               grad_valid, frame_done;

    int checks = 0;
    int errors = 0;
    int stray  = 0;

    logic [7:0]         img [H][W];
    logic               obs_v [N];
    logic               obs_d [N];
    logic signed [10:0] obs_gx [N];
    logic signed [10:0] obs_gy [N];

    sobel_gradient_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .frame_start (frame_start),
        .pixel_valid (pixel_valid),
        .pixel_in    (pixel_in),
        .gx_out      (gx_out),
        .gy_out      (gy_out),
        .grad_valid  (grad_valid),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: a result exists for every pixel whose 3x3 neighbourhood lies inside
    // the image (or for every pixel with border zeroing); kernels are evaluated directly.
    function automatic bit exp_valid(input int i);
`ifdef SOBEL_BORDER_ZERO_EN
        return 1'b1;
`else
        return (i / W >= 2) && (i % W >= 2);
`endif
    endfunction

    function automatic int exp_grad(input int i, input bit vertical);
        int r = i / W;
        int c = i % W;
        int s = 0;
        if (r < 2 || c < 2) return 0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                int k;
                if (vertical) k = (dr - 1) * ((dc == 1) ? 2 : 1);
                else          k = (dc - 1) * ((dr == 1) ? 2 : 1);
                s += k * int'(img[r - 2 + dr][c - 2 + dc]);
            end
        end
        return s;
    endfunction

    function automatic bit exp_done(input int i);
        return (i == N - 1) && exp_valid(i);
    endfunction

    // Drives npix pixels of img in raster order with random idle gaps and records,
    // for every accepted pixel, what the outputs show one cycle later.
    task automatic run_frame(input int npix, input int max_gap, input bit fs);
        int sched[$];
        int pend = -1;
        stray = 0;
        for (int i = 0; i < N; i++) begin
            obs_v[i] = 1'b0; obs_d[i] = 1'b0; obs_gx[i] = '0; obs_gy[i] = '0;
        end
        for (int i = 0; i < npix; i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) sched.push_back(-1);
            sched.push_back(i);
        end
        for (int k = 0; k <= sched.size(); k++) begin
            if (k < sched.size() && sched[k] >= 0) begin
                pixel_valid = 1'b1;
                pixel_in    = img[sched[k] / W][sched[k] % W];
                frame_start = fs && (sched[k] == 0);
            end else begin
                pixel_valid = 1'b0;
                pixel_in    = 8'($urandom);
                frame_start = 1'b0;
            end
            @(posedge clk); #1;
            if (pend >= 0) begin
                obs_v[pend]  = grad_valid;
                obs_d[pend]  = frame_done;
                obs_gx[pend] = gx_out;
                obs_gy[pend] = gy_out;
            end else if (grad_valid || frame_done) begin
                stray++;
            end
            pend = (k < sched.size()) ? sched[k] : -1;
        end
        pixel_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic fill_flat(input logic [7:0] v);
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
    endtask

    task automatic fill_vertical();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c < 2) ? 8'd0 : 8'd255;
    endtask

    task automatic fill_horizontal();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (r < 2) ? 8'd255 : 8'd0;
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'($urandom);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (grad_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", grad_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", frame_done); end
        checks++; if (gx_out !== 11'sd0) begin errors++; $display("FAIL reset_gx: got %0d expected 0", gx_out); end
        checks++; if (gy_out !== 11'sd0) begin errors++; $display("FAIL reset_gy: got %0d expected 0", gy_out); end
        n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_flat();
        int cnt = 0;
        int ecnt = 0;
        fill_flat(8'd100);
        run_frame(N, 0, 1'b0);
        for (int i = 0; i < N; i++) begin
            cnt  += int'(obs_v[i]);
            ecnt += int'(exp_valid(i));
            checks++;
            if (obs_v[i] !== exp_valid(i) || obs_d[i] !== exp_done(i) ||
                (exp_valid(i) && (obs_gx[i] !== 11'sd0 || obs_gy[i] !== 11'sd0))) begin
                errors++;
                $display("FAIL flat px%0d: got v=%0b d=%0b gx=%0d gy=%0d expected v=%0b d=%0b gx=0 gy=0",
                         i, obs_v[i], obs_d[i], obs_gx[i], obs_gy[i], exp_valid(i), exp_done(i));
            end
        end
        checks++; if (cnt !== ecnt) begin errors++; $display("FAIL flat_count: got %0d expected %0d", cnt, ecnt); end
        checks++; if (stray !== 0) begin errors++; $display("FAIL flat_stray: got %0d expected 0", stray); end
    endtask

    task automatic test_vertical_edge();
        fill_vertical();
        run_frame(N, 0, 1'b1);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs_v[i] !== exp_valid(i) || obs_d[i] !== exp_done(i) || (exp_valid(i) &&
                (obs_gx[i] !== 11'(exp_grad(i, 1'b0)) || obs_gy[i] !== 11'(exp_grad(i, 1'b1))))) begin
                errors++;
                $display("FAIL vedge px%0d: got v=%0b d=%0b gx=%0d gy=%0d expected v=%0b d=%0b gx=%0d gy=%0d",
                         i, obs_v[i], obs_d[i], obs_gx[i], obs_gy[i], exp_valid(i), exp_done(i),
                         exp_grad(i, 1'b0), exp_grad(i, 1'b1));
            end
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL vedge_stray: got %0d expected 0", stray); end
    endtask

    task automatic test_horizontal_edge();
        fill_horizontal();
        run_frame(N, 0, 1'b1);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs_v[i] !== exp_valid(i) || obs_d[i] !== exp_done(i) || (exp_valid(i) &&
                (obs_gx[i] !== 11'(exp_grad(i, 1'b0)) || obs_gy[i] !== 11'(exp_grad(i, 1'b1))))) begin
                errors++;
                $display("FAIL hedge px%0d: got v=%0b d=%0b gx=%0d gy=%0d expected v=%0b d=%0b gx=%0d gy=%0d",
                         i, obs_v[i], obs_d[i], obs_gx[i], obs_gy[i], exp_valid(i), exp_done(i),
                         exp_grad(i, 1'b0), exp_grad(i, 1'b1));
            end
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL hedge_stray: got %0d expected 0", stray); end
    endtask

    task automatic test_idle_gaps();
        fill_vertical();
        run_frame(N, 3, 1'b1);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs_v[i] !== exp_valid(i) || obs_d[i] !== exp_done(i) || (exp_valid(i) &&
                (obs_gx[i] !== 11'(exp_grad(i, 1'b0)) || obs_gy[i] !== 11'(exp_grad(i, 1'b1))))) begin
                errors++;
                $display("FAIL gaps px%0d: got v=%0b d=%0b gx=%0d gy=%0d expected v=%0b d=%0b gx=%0d gy=%0d",
                         i, obs_v[i], obs_d[i], obs_gx[i], obs_gy[i], exp_valid(i), exp_done(i),
                         exp_grad(i, 1'b0), exp_grad(i, 1'b1));
            end
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL gaps_stray: got %0d expected 0", stray); end
    endtask

    task automatic test_frame_restart();
        fill_random();
        run_frame(7, 1, 1'b0);
        fill_vertical();
        run_frame(N, 0, 1'b1);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs_v[i] !== exp_valid(i) || obs_d[i] !== exp_done(i) || (exp_valid(i) &&
                (obs_gx[i] !== 11'(exp_grad(i, 1'b0)) || obs_gy[i] !== 11'(exp_grad(i, 1'b1))))) begin
                errors++;
                $display("FAIL restart px%0d: got v=%0b d=%0b gx=%0d gy=%0d expected v=%0b d=%0b gx=%0d gy=%0d",
                         i, obs_v[i], obs_d[i], obs_gx[i], obs_gy[i], exp_valid(i), exp_done(i),
                         exp_grad(i, 1'b0), exp_grad(i, 1'b1));
            end
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL restart_stray: got %0d expected 0", stray); end
    endtask

    task automatic test_reset_midframe();
        fill_vertical();
        run_frame(10, 0, 1'b1);
        pixel_valid = 1'b1;
        pixel_in    = img[2][2];
        @(posedge clk); #1;
        pixel_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (grad_valid !== 1'b1 || gx_out !== 11'(exp_grad(10, 1'b0))) begin
            errors++; $display("FAIL midrst_pre: got v=%0b gx=%0d expected v=1 gx=%0d", grad_valid, gx_out, exp_grad(10, 1'b0));
        end
        #2 n_rst = 1'b0;
        #1;
        checks++; if (grad_valid !== 1'b0 || frame_done !== 1'b0 || gx_out !== 11'sd0 || gy_out !== 11'sd0) begin
            errors++; $display("FAIL midrst_clear: got v=%0b d=%0b gx=%0d gy=%0d expected all 0", grad_valid, frame_done, gx_out, gy_out);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        fill_horizontal();
        run_frame(N, 0, 1'b0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs_v[i] !== exp_valid(i) || obs_d[i] !== exp_done(i) || (exp_valid(i) &&
                (obs_gx[i] !== 11'(exp_grad(i, 1'b0)) || obs_gy[i] !== 11'(exp_grad(i, 1'b1))))) begin
                errors++;
                $display("FAIL midrst px%0d: got v=%0b d=%0b gx=%0d gy=%0d expected v=%0b d=%0b gx=%0d gy=%0d",
                         i, obs_v[i], obs_d[i], obs_gx[i], obs_gy[i], exp_valid(i), exp_done(i),
                         exp_grad(i, 1'b0), exp_grad(i, 1'b1));
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 4; f++) begin
            fill_random();
            run_frame(N, (f % 2) * 2, 1'b0);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (obs_v[i] !== exp_valid(i) || obs_d[i] !== exp_done(i) || (exp_valid(i) &&
                    (obs_gx[i] !== 11'(exp_grad(i, 1'b0)) || obs_gy[i] !== 11'(exp_grad(i, 1'b1))))) begin
                    errors++;
                    $display("FAIL b2b f%0d px%0d: got v=%0b d=%0b gx=%0d gy=%0d expected v=%0b d=%0b gx=%0d gy=%0d",
                             f, i, obs_v[i], obs_d[i], obs_gx[i], obs_gy[i], exp_valid(i), exp_done(i),
                             exp_grad(i, 1'b0), exp_grad(i, 1'b1));
                end
            end
            checks++; if (stray !== 0) begin errors++; $display("FAIL b2b_stray f%0d: got %0d expected 0", f, stray); end
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_vertical_edge();
        test_horizontal_edge();
        test_idle_gaps();
        test_frame_restart();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
